// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, read-mode enum and width helpers.
package fifo_pkg;

   localparam int FIFO_WIDTH_DEFAULT = 8;
   localparam int FIFO_DEPTH_DEFAULT = 16;

   typedef enum logic {
      RD_REG  = 1'b0,
      RD_FWFT = 1'b1
   } rd_mode_e;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   // Pointers carry one extra wrap bit above the address bits.
   function automatic int ptr_width(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port DEPTH x WIDTH storage: synchronous write, asynchronous read.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter  int WIDTH = FIFO_WIDTH_DEFAULT,
   parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             write,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic [AW-1:0]    read_addr,
   output logic [WIDTH-1:0] read_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (write) mem[write_addr] <= write_data;
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_sync.sv
// Parametrised synchronous FIFO with count, almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered output.
module fifo_sync
   import fifo_pkg::*;
#(
   parameter  int WIDTH    = FIFO_WIDTH_DEFAULT,
   parameter  int DEPTH    = FIFO_DEPTH_DEFAULT,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 2,
   localparam int AW       = clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             push,
   input  logic             pop,
   input  logic             clear_err,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

`ifdef FIFO_FWFT_EN
   localparam rd_mode_e READ_MODE = RD_FWFT;
`else
   localparam rd_mode_e READ_MODE = RD_REG;
`endif

   localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [WIDTH-1:0] head;

   assign empty        = (wr_ptr == rd_ptr);
   assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count        = wr_ptr - rd_ptr;
   assign almost_empty = (count <= AE_CNT);
   assign almost_full  = (count >= AF_CNT);

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         // A new error in the same cycle as clear_err keeps the flag set.
         overflow  <= (push && full)  || (overflow  && !clear_err);
         underflow <= (pop  && empty) || (underflow && !clear_err);
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clock      (clock),
      .write      (push_ok && !reset),
      .write_addr (wr_ptr[AW-1:0]),
      .write_data (data_in),
      .read_addr  (rd_ptr[AW-1:0]),
      .read_data  (head)
   );

   if (READ_MODE == RD_FWFT) begin : g_fwft
      assign data_out = head;
      assign valid    = !empty;
   end else begin : g_reg
      always_ff @(posedge clock) begin
         if (reset) begin
            data_out <= '0;
            valid    <= 1'b0;
         end else begin
            valid <= pop_ok;
            if (pop_ok) data_out <= head;
         end
      end
   end

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync (WIDTH=8, DEPTH=4): directed scenarios plus
// randomized traffic, all compared every cycle against a queue-based model.
module tb_fifo_sync;

   localparam int W = 8;
   localparam int D = 4;

   logic         clock = 1'b0;
   logic         reset, push, pop, clear_err;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic         valid, empty, full, almost_empty, almost_full;
   logic [2:0]   count;
   logic         overflow, underflow;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   // Reference model: a queue plus the sticky flags and the last popped word.
   logic [W-1:0] q[$];
   bit           m_ovf, m_unf, m_valid;
   logic [W-1:0] m_data;

   always #5 clock = ~clock;

   fifo_sync #(
      .WIDTH    (W),
      .DEPTH    (D),
      .AF_LEVEL (3),
      .AE_LEVEL (1)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .data_in      (data_in),
      .push         (push),
      .pop          (pop),
      .clear_err    (clear_err),
      .data_out     (data_out),
      .valid        (valid),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return at negedge.
   task automatic step(input bit p, input bit o, input logic [W-1:0] d,
                       input bit c, input bit r);
      bit was_full, was_empty;
      push = p; pop = o; data_in = d; clear_err = c; reset = r;
      @(posedge clock);
      if (r) begin
         q.delete();
         m_ovf = 0; m_unf = 0; m_valid = 0; m_data = '0;
      end else begin
         was_full  = (q.size() == D);
         was_empty = (q.size() == 0);
         m_valid = o && !was_empty;
         if (m_valid) m_data = q.pop_front();
         if (p && !was_full) q.push_back(d);
         m_ovf = (p && was_full)  || (m_ovf && !c);
         m_unf = (o && was_empty) || (m_unf && !c);
      end
      @(negedge clock);
   endtask

   task automatic chk_pop(input string name, input logic [W-1:0] exp);
`ifndef FIFO_FWFT_EN
      chk({name, "_valid"}, valid, 1);
      chk({name, "_data"}, data_out, exp);
`else
      chk({name, "_head"}, data_out, exp);
`endif
   endtask

   always @(negedge clock) begin
      if (check_en) begin
         chk("count", count, q.size());
         chk("empty", empty, q.size() == 0);
         chk("full", full, q.size() == D);
         chk("almost_empty", almost_empty, q.size() <= 1);
         chk("almost_full", almost_full, q.size() >= 3);
         chk("overflow", overflow, m_ovf);
         chk("underflow", underflow, m_unf);
`ifdef FIFO_FWFT_EN
         chk("valid", valid, q.size() != 0);
         if (q.size() != 0) chk("data_out", data_out, q[0]);
`else
         chk("valid", valid, m_valid);
         chk("data_out", data_out, m_data);
`endif
      end
   end

   initial begin
      logic [W-1:0] fill [4];
      logic [W-1:0] seq  [10];
      fill = '{8'hF1, 8'hFA, 8'h91, 8'h5C};
      m_data = '0;

      step(0, 0, '0, 0, 1);
      step(0, 0, '0, 0, 1);
      check_en = 1'b1;
      step(0, 0, '0, 0, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ae", almost_empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
`ifndef FIFO_FWFT_EN
      chk("rst_valid", valid, 0);
      chk("rst_data", data_out, 0);
`endif
      chk("rst_err", {overflow, underflow}, 0);

      // Fill to full, then overflow and clear.
      for (int unsigned i = 0; i < 4; i++) begin
         step(1, 0, fill[i], 0, 0);
         chk("fill_count", count, i + 1);
      end
      chk("fill_af", almost_full, 1);
      chk("fill_full", full, 1);
      step(1, 0, 8'h77, 0, 0);
      chk("ovf_count", count, 4);
      chk("ovf_set", overflow, 1);
      step(1, 0, 8'h78, 1, 0);
      chk("ovf_set_wins", overflow, 1);
      step(0, 0, '0, 0, 0);
      chk("ovf_sticky", overflow, 1);
      step(0, 0, '0, 1, 0);
      chk("ovf_clear", overflow, 0);

      // Drain in order.
      for (int unsigned i = 0; i < 4; i++) begin
         step(0, 1, '0, 0, 0);
         chk_pop("drain", fill[i]);
      end
      chk("drain_empty", empty, 1);

      // Push and pop together on empty: push only, underflow sets.
      step(1, 1, 8'hA5, 0, 0);
      chk("unf_count", count, 1);
      chk("unf_set", underflow, 1);
      step(0, 1, '0, 1, 0);
      chk_pop("unf_next", 8'hA5);

      // Steady state across pointer wrap.
      step(1, 0, 8'hE0, 0, 0);
      step(1, 0, 8'hE1, 0, 0);
      seq[0] = 8'hE0;
      seq[1] = 8'hE1;
      for (int unsigned i = 2; i < 10; i++) seq[i] = W'(i - 2);
      for (int unsigned i = 0; i < 10; i++) begin
         step(1, 1, W'(i), 0, 0);
         chk("steady_count", count, 2);
         chk_pop("steady", seq[i]);
      end
      step(1, 0, 8'h0A, 0, 0);
      step(1, 0, 8'h0B, 0, 0);
      step(1, 1, 8'h0C, 0, 0);
      chk("fullpp_count", count, 3);
      chk("fullpp_ovf", overflow, 1);
      chk_pop("fullpp", 8'h08);

      // Reset mid-stream discards contents.
      step(0, 0, '0, 0, 1);
      chk("mrst_count", count, 0);
      chk("mrst_empty", empty, 1);
      step(1, 0, 8'h3C, 0, 0);
      step(0, 1, '0, 0, 0);
      chk_pop("mrst_pop", 8'h3C);

      // Randomized traffic, alternating fill-biased and drain-biased phases.
      for (int unsigned i = 0; i < 3000; i++) begin
         int unsigned pp, po;
         pp = ((i / 150) % 2 == 0) ? 70 : 30;
         po = 100 - pp;
         step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < po,
              W'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
      end

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
